imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 43 ++++
 rtl/imem_word_serializer.sv | 49 ++++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and byte-lane helper for the byte-wide instruction memory
//
// Purpose:
//   Holds the loader state encoding, the word/byte geometry and the big-end-first
//   lane selector. The fetch side assembles words with the same constants, so
//   loader and fetch agree on byte order by construction.
//
// Contents:
//   state_t         loader session states
//   BYTES_PER_WORD  bytes per instruction word
//   IDX_BITS        width of the byte index within a word
//   LAST_IDX        byte index of the final byte of a word
//   lane()          byte of a word for a given index, index 0 = word[31:24]

package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_BITS       = $clog2(BYTES_PER_WORD);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTES_PER_WORD - 1);

  // Index 0 is the most significant byte, so the byte stored at the lowest
  // address is word[31:24] and a fetch reads the word back unchanged.
  function automatic logic [7:0] lane(input logic [31:0] word,
                                      input logic [IDX_BITS-1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = word[31:24];
      2'd1:    sel = word[23:16];
      2'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// rtl/imem_word_serializer.sv - holds one instruction word and presents it a byte at a time
//
// Purpose:
//   Latches a 32-bit word and walks a byte index through it, presenting the
//   currently selected byte and a flag marking the final byte of the word.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   load       in   1    capture word_in and restart at byte index 0
//   word_in    in   32   word to serialise
//   advance    in   1    step to the next byte (wraps to 0 after the last byte)
//   byte_data  out  8    byte selected by the current index
//   last_byte  out  1    current index is the final byte of the word

module imem_word_serializer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        advance,
  output logic [7:0]  byte_data,
  output logic        last_byte
);

  logic [31:0]         word_q;
  logic [IDX_BITS-1:0] idx;

  // The index wraps naturally back to 0 after the last byte, so between words
  // the byte output keeps showing the top byte of the previous word instead of
  // toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx    <= '0;
    end else if (load) begin
      word_q <= word_in;
      idx    <= '0;
    end else if (advance) begin
      idx    <= idx + 1'b1;
    end
  end

  assign byte_data = lane(word_q, idx);
  assign last_byte = (idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serialises 32-bit instruction words into byte writes on the imem port
//
// Purpose:
//   Accepts instruction words over a valid/ready stream during a load session
//   and writes each as four consecutive bytes, most significant byte first,
//   starting at the session base address. Flags an address wrap.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          pulse: begin a session at base_addr (ignored unless idle)
//   base_addr  in   BITS_ADDR  first byte address of the session
//   in_valid   in   1          in_word/in_last valid
//   in_ready   out  1          a word can be accepted this cycle
//   in_word    in   32         instruction word
//   in_last    in   1          final word of the session
//   mem_we     out  1          byte write strobe
//   mem_addr   out  BITS_ADDR  byte write address
//   mem_wdata  out  BITS_DATA  byte write data
//   busy       out  1          session in progress
//   done       out  1          one-cycle pulse after the final byte is written
//   wrap_err   out  1          sticky: the write address wrapped to 0

module imem_loader
  import imem_pkg::*;
#(
  parameter int BITS_DATA = 8,
  parameter int BITS_ADDR = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BITS_ADDR-1:0] base_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_word,
  input  logic                 in_last,
  output logic                 mem_we,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap_err
);

  if (BITS_DATA != 8) begin : g_bad_data_width
    $error("imem_loader: BITS_DATA must be 8");
  end

  state_t               state;
  state_t               state_next;

  logic                 load_base;
  logic                 load_word;
  logic                 advance;
  logic                 last_q;
  logic [BITS_ADDR-1:0] addr;
  logic [7:0]           byte_data;
  logic                 last_byte;

  imem_word_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_word),
    .word_in   (in_word),
    .advance   (advance),
    .byte_data (byte_data),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is only honoured from IDLE; in RECV, WR and DONE it has no effect
  // on the address counter or the wrap flag.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_base  = 1'b0;
    load_word  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_base  = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          load_word  = 1'b1;
          state_next = WR;
        end
      end
      WR: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        advance = 1'b1;
        if (last_byte) begin
          state_next = last_q ? DONE : RECV;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else if (load_word) begin
      last_q <= in_last;
    end
  end

  // The byte counter runs across word boundaries for the whole session; it
  // only reloads on an honoured start. Stepping past all-ones lands on 0 and
  // raises the sticky wrap flag, and writing simply carries on from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      wrap_err <= 1'b0;
    end else if (load_base) begin
      addr     <= base_addr;
      wrap_err <= 1'b0;
    end else if (mem_we) begin
      addr <= addr + 1'b1;
      if (&addr) begin
        wrap_err <= 1'b1;
      end
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = byte_data;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader

module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        in_last;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        wrap_err;

  imem_loader #(.BITS_DATA(8), .BITS_ADDR(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .wrap_err  (wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem_img [256];
  int         checks;
  int         failures;
  int         writes;
  bit         expect_done;

  logic [7:0] model_addr;
  bit         model_wrap;

  // Monitor: every byte write must be the next one the model predicted; done
  // must appear exactly in the cycle after a session's final byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      expect_done = 1'b0;
    end else begin
      if (expect_done || done) begin
        checks++;
        if (done !== expect_done) begin
          failures++;
          $display("FAIL done_timing actual=%0b expected=%0b t=%0t", done, expect_done, $time);
        end
      end
      expect_done = 1'b0;
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%02h data=%02h expected=none t=%0t",
                   mem_addr, mem_wdata, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            failures++;
            $display("FAIL write actual=%02h:%02h expected=%02h:%02h t=%0t",
                     mem_addr, mem_wdata, e.addr, e.data, $time);
          end
          if (e.last) expect_done = 1'b1;
        end
        mem_img[mem_addr] = mem_wdata;
        writes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({name, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    chk({name, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_wrap_err"}, {31'd0, wrap_err}, 32'd0);
  endtask

  task automatic do_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start      = 1'b0;
    base_addr  = 8'h99;
    model_addr = base;
    model_wrap = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic last);
    for (int k = 0; k < 4; k++) begin
      wr_t e;
      e.addr = model_addr;
      e.data = 8'(w >> (24 - 8 * k));
      e.last = last && (k == 3);
      exp_q.push_back(e);
      if (model_addr == 8'hFF) model_wrap = 1'b1;
      model_addr = model_addr + 8'd1;
    end
  endtask

  // Offer one word; keep leaves in_valid asserted after acceptance, poke pulses
  // start mid-write (or in DONE for the last word), which must be ignored.
  task automatic send_word(input logic [31:0] w, input logic last, input int gap,
                           input bit keep, input bit poke);
    int n;
    int k;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    push_word(w, last);
    tick();
    if (!keep) in_valid = 1'b0;
    k = 1;
    if (!last) begin
      while (!in_ready && k < 20) begin
        if (poke && k == 2) begin
          start     = 1'b1;
          base_addr = 8'h99;
        end
        tick();
        start = 1'b0;
        k++;
      end
      chk("ready_latency", k, 5);
    end else begin
      while (!done && k < 20) begin
        tick();
        k++;
      end
      chk("done_latency", k, 5);
      if (poke) begin
        start     = 1'b1;
        base_addr = 8'h99;
      end
      tick();
      start = 1'b0;
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_width", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int w0;
    checks   = 0;
    failures = 0;
    writes   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 8'h00;
    in_valid  = 1'b0;
    in_word   = 32'h0;
    in_last   = 1'b0;
    model_addr = 8'h00;
    model_wrap = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: two-word session
    do_start(8'h10);
    send_word(32'h11223344, 1'b0, 0, 1'b0, 1'b0);
    send_word(32'hAABBCCDD, 1'b1, 0, 1'b0, 1'b0);
    chk("t1_img_lo", {mem_img[8'h10], mem_img[8'h11], mem_img[8'h12], mem_img[8'h13]}, 32'h11223344);
    chk("t1_img_hi", {mem_img[8'h14], mem_img[8'h15], mem_img[8'h16], mem_img[8'h17]}, 32'hAABBCCDD);

    // 2: in_valid held across three words
    w0 = writes;
    do_start(8'h20);
    send_word($urandom, 1'b0, 0, 1'b1, 1'b0);
    send_word($urandom, 1'b0, 0, 1'b1, 1'b0);
    send_word($urandom, 1'b1, 0, 1'b0, 1'b0);
    chk("t2_write_count", writes - w0, 12);

    // 3: address wrap
    do_start(8'hFE);
    send_word(32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b0);
    chk("t3_wrap_set", {31'd0, wrap_err}, 32'd1);
    repeat (3) tick();
    chk("t3_wrap_sticky", {31'd0, wrap_err}, 32'd1);
    chk("t3_img", {mem_img[8'hFE], mem_img[8'hFF], mem_img[8'h00], mem_img[8'h01]}, 32'hDEADBEEF);
    do_start(8'h30);
    chk("t3_wrap_clear", {31'd0, wrap_err}, 32'd0);
    send_word(32'h0F1E2D3C, 1'b1, 1, 1'b0, 1'b0);

    // 4: reset after two bytes of a word
    do_start(8'h80);
    in_valid = 1'b1;
    in_word  = 32'hCAFEF00D;
    in_last  = 1'b0;
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    push_word(32'hCAFEF00D, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t4_midreset");
    tick();
    tick();
    rst_n = 1'b1;
    model_wrap = 1'b0;
    tick();
    chk("t4_kept_bytes", {16'd0, mem_img[8'h80], mem_img[8'h81]}, 32'h0000CAFE);
    do_start(8'h40);
    send_word(32'h0BADC0DE, 1'b1, 0, 1'b0, 1'b0);

    // 5: start pulses while busy and in DONE are ignored
    do_start(8'h50);
    send_word(32'h55667788, 1'b0, 0, 1'b0, 1'b1);
    start     = 1'b1;
    base_addr = 8'h99;
    tick();
    start = 1'b0;
    send_word(32'h99AABBCC, 1'b1, 2, 1'b0, 1'b1);
    chk("t5_img", {mem_img[8'h54], mem_img[8'h55], mem_img[8'h56], mem_img[8'h57]}, 32'h99AABBCC);

    // 6: unaligned base, fetch-path read-back
    do_start(8'h03);
    send_word(32'h01020304, 1'b1, 0, 1'b0, 1'b0);
    chk("t6_fetch", {mem_img[8'h03], mem_img[8'h04], mem_img[8'h05], mem_img[8'h06]}, 32'h01020304);
    chk("t6_wrap", {31'd0, wrap_err}, 32'd0);

    // random sessions
    for (int s = 0; s < 30; s++) begin
      int nw;
      logic [7:0] b;
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 255));
      nw = $urandom_range(1, 4);
      do_start(b);
      for (int i = 0; i < nw; i++) begin
        bit last;
        last = (i == nw - 1);
        send_word($urandom, last, $urandom_range(0, 2),
                  !last && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) == 0);
      end
      chk("rand_wrap_err", {31'd0, wrap_err}, {31'd0, model_wrap});
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
